smi_self_flow_arbiter_control: RTL and testbench
================================================

Name: smi_self_flow_arbiter_control

Overview:
- Round-robin frame arbiter that merges NumPorts upstream SELF flows into one downstream SELF flow. It is the natural counterpart to the SELF fork controller.
- Arbitration is frame-locked. Once a port is granted, all of its flits pass through until a flit with end-of-frame set, so SMI messages are never interleaved.
- The output is a single registered pipeline stage carrying data plus the end-of-frame flag. It sits in front of shared SMI resources such as the memory port and the network egress.

Parameters:
- NumPorts, 4, number of arbitrated input flows (2..16).
- DataWidth, 64, flit data width in bits.
- WatchdogCycles, 1024, lock timeout threshold (used only with the optional feature).

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- ctrlInReady  input  NumPorts  per-port flit valid.
- ctrlInEofc  input  NumPorts  per-port end-of-frame flag, qualified by ctrlInReady.
- ctrlInData  input  NumPorts*DataWidth  per-port flit data; port i occupies bits [i*DataWidth +: DataWidth].
- ctrlInStop  output  NumPorts  per-port stop.
- ctrlOutReady  output  1  output flit valid (registered).
- ctrlOutEofc  output  1  output end-of-frame flag (registered).
- ctrlOutData  output  DataWidth  output flit data (registered).
- ctrlOutStop  input  1  downstream stop.
- grantIndex  output  clog2(NumPorts)  currently locked port; debug/routing tag, valid while grantActive.
- grantActive  output  1  high in LOCKED.

Behaviour:
- SELF transfer rule: a flit moves on a link in any cycle where Ready=1 and Stop=0. Ready and data must hold while stopped.
- Reset values (async on nrst low):
  - state=IDLE, ctrlOutReady=0, ctrlOutEofc=0, ctrlOutData=0.
  - rrPtr=NumPorts-1, so port 0 has first priority.
  - grantIndex=0, grantActive=0.
  - ctrlInStop all ones.
- Output register:
  - Can load when !outValid_q or !ctrlOutStop.
  - Loads the granted port's flit on an input transfer.
  - Clears outValid_q when the downstream transfer occurs and nothing is loaded.
- ctrlInStop[i] = !(grantActive and grantIndex==i) or (outValid_q and ctrlOutStop). It is combinational from registered state and ctrlOutStop only, never from ctrlInReady.
- FSM IDLE:
  - If any ctrlInReady is set, select the first requesting port scanning rrPtr+1, rrPtr+2, ... modulo NumPorts.
  - Register that port into grantIndex and go to LOCKED.
  - No flit is accepted in IDLE.
- FSM LOCKED:
  - Accept flits from grantIndex only.
  - On transfer of a flit with ctrlInEofc=1: rrPtr<=grantIndex, go to IDLE.
- Latency: request at cycle 0 → LOCKED at cycle 1 → first flit accepted at cycle 1 → ctrlOutReady=1 at cycle 2.
- Throughput: 1 flit/cycle within a frame. Exactly one IDLE bubble between frames.
- Boundary conditions:
  - Single-flit frame (Eofc on the first flit) costs 2 cycles per frame.
  - Granted port drops ctrlInReady mid-frame: stay LOCKED, no timeout unless the optional feature is compiled in.
  - Simultaneous final-flit accept and downstream stop: the output holds, stop propagates the next cycle; the flit is still committed.
  - Pointer wraps from NumPorts-1 to 0.
  - Only one requester: it is re-granted after each bubble.
  - Reset asserted mid-frame: the frame is discarded, output invalidated immediately, partial frame not resumed.

Optional Feature:
- Macro: SMI_FLOW_ARBITER_WATCHDOG_EN.
- With the macro:
  - A counter increments each LOCKED cycle with no input transfer. It resets to 0 on any transfer and in IDLE.
  - When the counter reaches WatchdogCycles, the sticky output watchdogError (1 bit, reset 0) sets, rrPtr<=grantIndex, and the FSM returns to IDLE (forced unlock).
  - watchdogError clears only on reset.
- Without the macro: no counter and no watchdogError port; the lock is held indefinitely.

Decomposition:
- Shared package smi_flow_pkg:
  - FSM state encoding (IDLE=1'b0, LOCKED=1'b1).
  - clog2 function.
  - Default DataWidth constant.
- One natural sub-module, smi_rr_priority_select: combinational rotate-priority pick. Takes the request vector and rrPtr; returns a one-hot grant, an index, and an any-request flag. It is reusable by other SMI arbiters.

Test Plan:
- Single request: port 2 sends a 3-flit frame (data 0xA1, 0xA2, 0xA3; Eofc on 0xA3), downstream never stopped → ctrlOutReady high cycles 2-4 carrying 0xA1..0xA3, Eofc=1 only on 0xA3, grantIndex=2.
- Fairness: all 4 ports continuously send single-flit frames after reset → grant order 0,1,2,3,0,…; one frame every 2 cycles.
- Frame lock: port 0 sends a 5-flit frame while port 1 requests → no port-1 flit appears before port 0's Eofc flit; port 1 follows after a 1-cycle bubble.
- Backpressure: ctrlOutStop=1 for 3 cycles mid-frame → ctrlInStop[grant]=1 during the hold; no flit lost or duplicated; output data is stable while stopped.
- Reset mid-frame: nrst pulled low after flit 2 of 4 → ctrlOutReady=0 immediately, state IDLE, rrPtr=3. After release, port 0 is granted first.
- Watchdog (macro on, WatchdogCycles=8): granted port 1 stalls after flit 1 → watchdogError=1 after 8 idle LOCKED cycles, FSM in IDLE, next grant goes to port 2 when port 2 is requesting.

Source files
------------

// File: rtl/smi_flow_pkg.sv
`default_nettype none
// ============================================================================
// Module   : smi_flow_pkg
// Desc     : Shared types and helpers for the SMI SELF flow arbiters.
// Revision : 1.0 - initial release
// ============================================================================
package smi_flow_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 64;

    // Never returns less than 1 so single-entry indices stay legal vectors.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/smi_self_flow_arbiter_control_if.sv
`default_nettype none
// ============================================================================
// Module   : smi_self_flow_arbiter_control_if
// Desc     : SELF links around the frame arbiter (NumPorts inputs, one output).
// Revision : 1.0 - initial release
// ============================================================================
interface smi_self_flow_arbiter_control_if #(
    parameter int NumPorts  = 4,
    parameter int DataWidth = smi_flow_pkg::DEFAULT_DATA_WIDTH
) ();
    localparam int IndexWidth = smi_flow_pkg::clog2(NumPorts);

    logic [NumPorts-1:0]           ctrlInReady;
    logic [NumPorts-1:0]           ctrlInEofc;
    logic [NumPorts*DataWidth-1:0] ctrlInData;
    logic [NumPorts-1:0]           ctrlInStop;
    logic                          ctrlOutReady;
    logic                          ctrlOutEofc;
    logic [DataWidth-1:0]          ctrlOutData;
    logic                          ctrlOutStop;
    logic [IndexWidth-1:0]         grantIndex;
    logic                          grantActive;

    modport master (
        output ctrlInReady, ctrlInEofc, ctrlInData, ctrlOutStop,
        input  ctrlInStop, ctrlOutReady, ctrlOutEofc, ctrlOutData,
        input  grantIndex, grantActive
    );

    modport slave (
        input  ctrlInReady, ctrlInEofc, ctrlInData, ctrlOutStop,
        output ctrlInStop, ctrlOutReady, ctrlOutEofc, ctrlOutData,
        output grantIndex, grantActive
    );
endinterface

`default_nettype wire

// File: rtl/smi_rr_priority_select.sv
`default_nettype none
// ============================================================================
// Module   : smi_rr_priority_select
// Desc     : Rotating-priority pick: first request after rr_ptr, modulo NumPorts.
// Revision : 1.0 - initial release
// ============================================================================
module smi_rr_priority_select #(
    parameter  int NumPorts   = 4,
    localparam int IndexWidth = smi_flow_pkg::clog2(NumPorts)
) (
    input  logic [NumPorts-1:0]   req,
    input  logic [IndexWidth-1:0] rr_ptr,
    output logic [NumPorts-1:0]   grant_onehot,
    output logic [IndexWidth-1:0] grant_index,
    output logic                  any_req
);

    always_comb begin : p_pick
        int                  cand;
        logic [IndexWidth-1:0] cand_idx;
        grant_onehot = '0;
        grant_index  = '0;
        any_req      = 1'b0;
        cand         = 0;
        cand_idx     = '0;
        for (int offset = 1; offset <= NumPorts; offset++) begin
            cand     = (int'(rr_ptr) + offset) % NumPorts;
            cand_idx = IndexWidth'(cand);
            if (!any_req && req[cand_idx]) begin
                any_req                = 1'b1;
                grant_onehot[cand_idx] = 1'b1;
                grant_index            = cand_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/smi_self_flow_arbiter_control.sv
`default_nettype none
// ============================================================================
// Module   : smi_self_flow_arbiter_control
// Desc     : Frame-locked round-robin merge of NumPorts SELF flows into one,
//            with a registered output stage. SMI_FLOW_ARBITER_WATCHDOG_EN adds
//            a lock timeout and the sticky watchdogError output.
// Revision : 1.0 - initial release
// ============================================================================
module smi_self_flow_arbiter_control
    import smi_flow_pkg::*;
#(
    parameter int NumPorts       = 4,
    parameter int DataWidth      = DEFAULT_DATA_WIDTH,
    parameter int WatchdogCycles = 1024
) (
    input  logic                            clk,
    input  logic                            nrst,
    smi_self_flow_arbiter_control_if.slave  bus
`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
    ,
    output logic                            watchdogError
`endif
);

    localparam int IndexWidth = clog2(NumPorts);

    if (NumPorts < 2 || NumPorts > 16 || WatchdogCycles < 1) begin : g_param_check
        $error("smi_self_flow_arbiter_control: parameter out of range");
    end

    arb_state_t              r_state;
    logic [IndexWidth-1:0]   r_rr_ptr;
    logic [IndexWidth-1:0]   r_grant_index;
    logic [NumPorts-1:0]     r_grant_mask;
    logic                    r_grant_active;
    logic                    r_out_valid;
    logic                    r_out_eofc;
    logic [DataWidth-1:0]    r_out_data;

    logic [NumPorts-1:0]     w_pick_onehot;
    logic [IndexWidth-1:0]   w_pick_index;
    logic                    w_any_req;
    logic                    w_out_stall;
    logic                    w_sel_ready;
    logic                    w_sel_eofc;
    logic [DataWidth-1:0]    w_sel_data;
    logic                    w_in_xfer;

    smi_rr_priority_select #(
        .NumPorts (NumPorts)
    ) u_pick (
        .req          (bus.ctrlInReady),
        .rr_ptr       (r_rr_ptr),
        .grant_onehot (w_pick_onehot),
        .grant_index  (w_pick_index),
        .any_req      (w_any_req)
    );

    // Stop depends only on registered grant state and ctrlOutStop, never on Ready.
    assign w_out_stall    = r_out_valid & bus.ctrlOutStop;
    assign bus.ctrlInStop = ~r_grant_mask | {NumPorts{w_out_stall}};

    assign w_sel_ready = bus.ctrlInReady[r_grant_index];
    assign w_sel_eofc  = bus.ctrlInEofc[r_grant_index];
    assign w_sel_data  = bus.ctrlInData[int'(r_grant_index)*DataWidth +: DataWidth];
    assign w_in_xfer   = r_grant_active & w_sel_ready & ~w_out_stall;

    assign bus.ctrlOutReady = r_out_valid;
    assign bus.ctrlOutEofc  = r_out_eofc;
    assign bus.ctrlOutData  = r_out_data;
    assign bus.grantIndex   = r_grant_index;
    assign bus.grantActive  = r_grant_active;

`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
    localparam int WdWidth = clog2(WatchdogCycles + 1);

    logic [WdWidth-1:0] r_wd_count;
    logic               r_wd_error;
    logic               w_wd_expire;

    assign w_wd_expire   = (r_state == LOCKED) && !w_in_xfer &&
                           (r_wd_count == WdWidth'(WatchdogCycles - 1));
    assign watchdogError = r_wd_error;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state        <= IDLE;
            r_rr_ptr       <= IndexWidth'(NumPorts - 1);
            r_grant_index  <= '0;
            r_grant_mask   <= '0;
            r_grant_active <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_eofc     <= 1'b0;
            r_out_data     <= '0;
`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
            r_wd_count     <= '0;
            r_wd_error     <= 1'b0;
`endif
        end else begin
            if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_eofc  <= w_sel_eofc;
                r_out_data  <= w_sel_data;
            end else if (!bus.ctrlOutStop) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state        <= LOCKED;
                        r_grant_index  <= w_pick_index;
                        r_grant_mask   <= w_pick_onehot;
                        r_grant_active <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_in_xfer && w_sel_eofc) begin
                        r_state        <= IDLE;
                        r_rr_ptr       <= r_grant_index;
                        r_grant_mask   <= '0;
                        r_grant_active <= 1'b0;
                    end
`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
                    else if (w_wd_expire) begin
                        r_state        <= IDLE;
                        r_rr_ptr       <= r_grant_index;
                        r_grant_mask   <= '0;
                        r_grant_active <= 1'b0;
                        r_wd_error     <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
            if (r_state != LOCKED || w_in_xfer || w_wd_expire) begin
                r_wd_count <= '0;
            end else begin
                r_wd_count <= r_wd_count + WdWidth'(1);
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_smi_self_flow_arbiter_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_smi_self_flow_arbiter_control
// Desc     : Directed and random stimulus against a frame-level arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_smi_self_flow_arbiter_control;
    import smi_flow_pkg::*;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int IW = clog2(NP);

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    smi_self_flow_arbiter_control_if #(.NumPorts(NP), .DataWidth(DW)) bus ();
`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
    logic watchdogError;
`endif

    smi_self_flow_arbiter_control #(
        .NumPorts       (NP),
        .DataWidth      (DW),
        .WatchdogCycles (8)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
`ifdef SMI_FLOW_ARBITER_WATCHDOG_EN
        ,
        .watchdogError (watchdogError)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Source side: per-port flit queues, MSB of each entry is end-of-frame.
    logic [DW:0] src_q [NP][$];
    logic [NP-1:0] pres;
    logic [DW:0] out_log [$];
    int generated;

    // Reference: who owns the output, who had it last, what sits in the output slot.
    bit          m_act;
    int          m_idx;
    int          m_last;
    bit          m_ov;
    logic        m_oe;
    logic [DW-1:0] m_od;

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = 1'b0;
        m_idx  = 0;
        m_last = NP - 1;
        m_ov   = 1'b0;
        m_oe   = 1'b0;
        m_od   = '0;
    endtask

    task automatic push_flit(input int p, input logic eofc, input logic [DW-1:0] data);
        src_q[p].push_back({eofc, data});
        generated++;
    endtask

    task automatic push_frame(input int p, input int len);
        for (int j = 0; j < len; j++) begin
            push_flit(p, (j == len - 1), {$urandom(), 16'h0, 8'(p), 8'(j)});
        end
    endtask

    task automatic drive_sources(input int pct);
        for (int i = 0; i < NP; i++) begin
            if (!pres[i] && src_q[i].size() > 0 && $urandom_range(99) < pct) pres[i] = 1'b1;
            bus.ctrlInReady[i] = pres[i];
            if (pres[i]) begin
                bus.ctrlInEofc[i]          = src_q[i][0][DW];
                bus.ctrlInData[i*DW +: DW] = src_q[i][0][DW-1:0];
            end else begin
                bus.ctrlInEofc[i]          = 1'b0;
                bus.ctrlInData[i*DW +: DW] = {$urandom(), $urandom()};
            end
        end
    endtask

    // Inputs are already driven; compare, advance the model, then cross one edge.
    task automatic step(input logic ostop);
        logic [NP-1:0] exp_stop;
        bit stall;
        bit found;
        int xport;
        bus.ctrlOutStop = ostop;
        #1;
        stall = m_ov && ostop;
        for (int i = 0; i < NP; i++) exp_stop[i] = !(m_act && m_idx == i) || stall;
        check("in_stop", bus.ctrlInStop, exp_stop);
        check("out_ready", bus.ctrlOutReady, m_ov);
        if (m_ov) check("out_flit", {bus.ctrlOutEofc, bus.ctrlOutData}, {m_oe, m_od});
        check("grant_active", bus.grantActive, m_act);
        if (m_act) check("grant_index", bus.grantIndex, m_idx[IW-1:0]);
        if (bus.ctrlOutReady && !ostop) out_log.push_back({bus.ctrlOutEofc, bus.ctrlOutData});

        xport = -1;
        if (m_act && pres[m_idx] && !stall) xport = m_idx;
        if (xport >= 0) begin
            m_ov = 1'b1;
            m_oe = src_q[xport][0][DW];
            m_od = src_q[xport][0][DW-1:0];
        end else if (!ostop) begin
            m_ov = 1'b0;
        end
        if (!m_act) begin
            found = 1'b0;
            for (int k = 1; k <= NP; k++) begin
                if (!found && pres[(m_last + k) % NP]) begin
                    found = 1'b1;
                    m_act = 1'b1;
                    m_idx = (m_last + k) % NP;
                end
            end
        end else if (xport >= 0 && src_q[xport][0][DW]) begin
            m_last = m_idx;
            m_act  = 1'b0;
        end

        @(posedge clk);
        #1;
        if (xport >= 0) begin
            void'(src_q[xport].pop_front());
            pres[xport] = 1'b0;
        end
    endtask

    task automatic do_reset();
        nrst            = 1'b0;
        pres            = '0;
        bus.ctrlInReady = '0;
        bus.ctrlInEofc  = '0;
        bus.ctrlInData  = '0;
        bus.ctrlOutStop = 1'b0;
        for (int i = 0; i < NP; i++) src_q[i].delete();
        out_log.delete();
        generated = 0;
        #1;
        check("rst_out_ready", bus.ctrlOutReady, 1'b0);
        check("rst_out_eofc", bus.ctrlOutEofc, 1'b0);
        check("rst_out_data", bus.ctrlOutData, '0);
        check("rst_grant_active", bus.grantActive, 1'b0);
        check("rst_grant_index", bus.grantIndex, '0);
        check("rst_in_stop", bus.ctrlInStop, {NP{1'b1}});
        model_reset();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic int queued_flits();
        int n = 0;
        for (int i = 0; i < NP; i++) n += src_q[i].size();
        return n;
    endfunction

    initial begin
        logic [DW:0] e;
        logic [DW:0] exp_flits [$];
        int p;
        int bad;
        int cur;
        int n;

        do_reset();

        // Single request: port 2, three flits, no backpressure.
        push_flit(2, 1'b0, 64'hA1);
        push_flit(2, 1'b0, 64'hA2);
        push_flit(2, 1'b1, 64'hA3);
        for (int c = 0; c < 7; c++) begin drive_sources(100); step(1'b0); end
        exp_flits = '{{1'b0, 64'hA1}, {1'b0, 64'hA2}, {1'b1, 64'hA3}};
        check("single_count", 32'(out_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < out_log.size(); k++) check("single_flit", out_log[k], exp_flits[k]);

        // Fairness: every port offers single-flit frames continuously.
        do_reset();
        for (int r = 0; r < 3; r++) for (int i = 0; i < NP; i++) push_frame(i, 1);
        for (int c = 0; c < 26; c++) begin drive_sources(100); step(1'b0); end
        check("fair_count", 32'(out_log.size()), 32'd12);
        for (int k = 0; k < out_log.size(); k++) begin
            e = out_log[k];
            check("fair_port", e[15:8], k % NP);
        end

        // Frame lock: port 1 waits for port 0's whole five-flit frame.
        do_reset();
        push_frame(0, 5);
        push_frame(1, 2);
        for (int c = 0; c < 12; c++) begin drive_sources(100); step(1'b0); end
        check("lock_count", 32'(out_log.size()), 32'd7);
        for (int k = 0; k < out_log.size(); k++) begin
            e = out_log[k];
            check("lock_order", e[15:0], (k < 5) ? {8'd0, 8'(k)} : {8'd1, 8'(k - 5)});
        end

        // Backpressure: three stalled cycles mid-frame.
        do_reset();
        push_frame(3, 6);
        for (int c = 0; c < 14; c++) begin
            drive_sources(100);
            step((c >= 4 && c < 7) ? 1'b1 : 1'b0);
        end
        check("bp_count", 32'(out_log.size()), 32'd6);
        for (int k = 0; k < out_log.size(); k++) begin
            e = out_log[k];
            check("bp_seq", e[15:0], {8'd3, 8'(k)});
        end

        // Random traffic with random stalls, then drain.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(2) == 0) begin
                p = $urandom_range(NP - 1);
                if (src_q[p].size() < 8) push_frame(p, $urandom_range(5, 1));
            end
            drive_sources(70);
            step(($urandom_range(99) < 30) ? 1'b1 : 1'b0);
        end
        n = 0;
        while ((queued_flits() > 0 || m_ov) && n < 2000) begin
            drive_sources(100);
            step(1'b0);
            n++;
        end
        check("rand_drain_timeout", 32'(n < 2000), 32'd1);
        check("rand_count", 32'(out_log.size()), 32'(generated));
        bad = 0;
        cur = -1;
        for (int k = 0; k < out_log.size(); k++) begin
            e = out_log[k];
            if (cur >= 0 && int'(e[15:8]) != cur) bad++;
            cur = e[DW] ? -1 : int'(e[15:8]);
        end
        check("rand_interleave", 32'(bad), 32'd0);

        // Reset mid-frame: two of four flits out, then reset; port 0 wins next.
        do_reset();
        push_frame(2, 4);
        n = 0;
        while (out_log.size() < 2 && n < 20) begin
            drive_sources(100);
            step(1'b0);
            n++;
        end
        check("midrst_progress", 32'(out_log.size()), 32'd2);
        #2;
        do_reset();
        for (int i = 0; i < NP; i++) push_frame(i, 1);
        for (int c = 0; c < 4; c++) begin drive_sources(100); step(1'b0); end
        check("midrst_count", 32'(out_log.size() >= 1), 32'd1);
        if (out_log.size() >= 1) begin
            e = out_log[0];
            check("midrst_first_port", e[15:8], 8'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
